// File: rtl/ibexc_rvfi_trace_fifo.sv
// Retirement-trace FIFO: packs each RVFI retirement into a 153-bit record and streams it to a trace sink.
// Overflow drops records, counts them, and tags the next accepted record with a gap bit.
module ibexc_rvfi_trace_fifo #(
    parameter int Depth = 16,
    parameter int CntW  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_en_i,
    input  logic                       flush_i,
    input  logic                       clr_lost_i,
    input  logic                       rvfi_valid_i,
    input  logic [63:0]                rvfi_order_i,
    input  logic                       rvfi_trap_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic [31:0]                rvfi_mem_addr_i,
    input  logic [3:0]                 rvfi_mem_rmask_i,
    input  logic [3:0]                 rvfi_mem_wmask_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [152:0]               trace_rec_o,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       trace_lost_o,
    output logic [CntW-1:0]            lost_cnt_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = $clog2(Depth + 1);

    logic [152:0]    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            gap_q, gap_d;
    logic [CntW-1:0] lost_q, lost_d;

    logic         cap, pop, push, drop, full;
    logic [152:0] rec_new;
    logic         unused_order;

    assign unused_order = ^rvfi_order_i[63:16];

    // Stream handshake: a record transfers on any cycle where trace_valid_o and trace_ready_i
    // are both high; the head record holds steady while valid is high and ready is low.
    assign full = (level_q == LvlW'(Depth));
    assign cap  = trace_en_i & rvfi_valid_i & ~flush_i;
    assign pop  = trace_valid_o & trace_ready_i & ~flush_i;
    assign push = cap & (~full | pop);
    assign drop = cap & ~push;

    assign rec_new = {gap_q,
                      rvfi_trap_i,
                      rvfi_rd_addr_i,
                      |rvfi_mem_wmask_i,
                      |rvfi_mem_rmask_i,
                      rvfi_order_i[15:0],
                      rvfi_pc_rdata_i,
                      rvfi_insn_i,
                      (rvfi_rd_addr_i == 5'd0) ? 32'd0 : rvfi_rd_wdata_i,
                      ((rvfi_mem_rmask_i | rvfi_mem_wmask_i) == 4'd0) ? 32'd0 : rvfi_mem_addr_i};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        gap_d    = gap_q;
        lost_d   = lost_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            gap_d    = 1'b0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (push && !pop)      level_d = level_q + LvlW'(1);
            else if (pop && !push) level_d = level_q - LvlW'(1);
            if (push) gap_d = 1'b0;
            if (drop) gap_d = 1'b1;
        end
        // A clear that coincides with a drop still accounts for that drop.
        if (clr_lost_i)                  lost_d = drop ? CntW'(1) : '0;
        else if (drop && lost_q != '1)   lost_d = lost_q + CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            gap_q    <= 1'b0;
            lost_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            gap_q    <= gap_d;
            lost_q   <= lost_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rec_new;
    end

    // Stale storage is masked so an empty FIFO always presents an all-zero record.
    assign trace_valid_o = (level_q != '0);
    assign trace_rec_o   = trace_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o       = level_q;
    assign lost_cnt_o    = lost_q;
    assign trace_lost_o  = |lost_q;
endmodule
